updown_mod_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/count_prescaler.sv | 42 ++++
 rtl/updown_mod_counter.sv | 111 +++++++++++
 tb/tb_updown_mod_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared constants for the up/down modulo counter family.
//   DIR_UP / DIR_DOWN   : encodings of the up_dn input
//   MODE_WRAP / MODE_SAT: encodings of the sat input
//   DEFAULT_WIDTH       : default counter width in bits
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic MODE_SAT  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;

endpackage : counter_pkg

// File: rtl/count_prescaler.sv
// ---------------------------------------------------------------------------
// count_prescaler
// Divides enabled cycles by PRESCALE. tick is asserted combinationally on
// every PRESCALE-th enabled cycle, so the first tick arrives PRESCALE enabled
// cycles after reset or clear.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   en    : cycle qualifier; phase advances only while en=1
//   clr   : synchronous clear; wins over en and suppresses tick
//   tick  : step qualifier for the counter
// ---------------------------------------------------------------------------
module count_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && !clr && (phase == LAST);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

endmodule : count_prescaler

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
// Generic-width up/down counter with programmable terminal value MAX_VAL,
// synchronous parallel load (clamped to MAX_VAL), count enable and run-time
// wrap/saturate selection. Priority per edge: reset > load > en.
//
// Optional feature: define COUNTER_PRESCALE_EN to step only on every
// PRESCALE-th enabled cycle (prescaler cleared by reset and load). Without
// the macro every enabled cycle steps and PRESCALE is only range-checked.
//
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset
//   en       : count enable
//   up_dn    : 1 = count up, 0 = count down
//   sat      : 1 = saturate at limits, 0 = wrap around
//   load     : synchronous load strobe
//   load_val : value to load (values above MAX_VAL load MAX_VAL)
//   count    : registered count, always within 0..MAX_VAL
//   at_limit : combinational, count sits at the limit in the current direction
//   wrap     : registered one-cycle pulse after a wrapping step
// ---------------------------------------------------------------------------
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_limit,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be at least 2");
  end
  if ((MAX_VAL < 1) || (MAX_VAL > (2**WIDTH - 1))) begin : g_bad_max
    $error("updown_mod_counter: MAX_VAL must lie in 1 .. 2**WIDTH-1");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be at least 2");
  end

  logic             step;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;

`ifdef COUNTER_PRESCALE_EN
  count_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (step)
  );
`else
  assign step = 1'b1;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    count_d = count;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en && step) begin
      if (up_dn == DIR_UP) begin
        if (count != MAX_C) begin
          count_d = count + 1'b1;
        end else if (sat == MODE_WRAP) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count != '0) begin
          count_d = count - 1'b1;
        end else if (sat == MODE_WRAP) begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_d;
      wrap  <= wrap_d;
    end
  end

  assign at_limit = (up_dn == DIR_UP) ? (count == MAX_C) : (count == '0);

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_mod_counter
// Self-checking bench: a directed vector table, hand-written corner
// sequences, and randomized stimulus compared with a behavioural model.
// u_dut uses WIDTH=4, MAX_VAL=9; u_def uses the default parameters.
// ---------------------------------------------------------------------------
module tb_updown_mod_counter;

  localparam int W   = 4;
  localparam int MAX = 9;
  localparam int PS  = 4;

  logic         clk = 1'b0;
  logic         reset, en, up_dn, sat, load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         at_limit, wrap;

  logic         d_reset, d_en, d_up_dn, d_sat, d_load;
  logic [3:0]   d_load_val;
  logic [3:0]   d_count;
  logic         d_at_limit, d_wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAX), .PRESCALE(PS)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .at_limit (at_limit),
    .wrap     (wrap)
  );

  updown_mod_counter #(.PRESCALE(PS)) u_def (
    .clk      (clk),
    .reset    (d_reset),
    .en       (d_en),
    .up_dn    (d_up_dn),
    .sat      (d_sat),
    .load     (d_load),
    .load_val (d_load_val),
    .count    (d_count),
    .at_limit (d_at_limit),
    .wrap     (d_wrap)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       ld;
    logic [3:0] lv;
    int         c;
    logic       w;
    logic       al;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic s,
                     input logic l, input int v, input int c, input logic w,
                     input logic al);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.sat = s; x.ld = l; x.lv = 4'(v);
    x.c = c; x.w = w; x.al = al;
    vecs.push_back(x);
  endtask

  // Drive one cycle of u_dut inputs at the falling edge, let the rising edge
  // take them, then sample just after it.
  task automatic cyc(input logic r, input logic e, input logic u, input logic s,
                     input logic l, input logic [W-1:0] v);
    @(negedge clk);
    reset = r; en = e; up_dn = u; sat = s; load = l; load_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic dcyc(input logic r, input logic e, input logic l, input logic [3:0] v);
    @(negedge clk);
    d_reset = r; d_en = e; d_up_dn = 1'b1; d_sat = 1'b0; d_load = l; d_load_val = v;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: counts in plain integers from the stated rules.
  int m_count, m_pre;
  logic m_wrap;

  task automatic model_step(input logic r, input logic e, input logic u,
                            input logic s, input logic l, input int v);
    bit do_step;
    if (!r) begin
      m_count = 0; m_wrap = 0; m_pre = 0;
    end else if (l) begin
      m_count = (v > MAX) ? MAX : v; m_wrap = 0; m_pre = 0;
    end else if (!e) begin
      m_wrap = 0;
    end else begin
`ifdef COUNTER_PRESCALE_EN
      m_pre = m_pre + 1;
      do_step = (m_pre == PS);
      if (do_step) m_pre = 0;
`else
      do_step = 1;
`endif
      m_wrap = 0;
      if (do_step) begin
        if (u) begin
          if (m_count < MAX) m_count = m_count + 1;
          else if (!s) begin m_count = 0; m_wrap = 1; end
        end else begin
          if (m_count > 0) m_count = m_count - 1;
          else if (!s) begin m_count = MAX; m_wrap = 1; end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    d_reset = 1'b0; d_en = 1'b0; d_up_dn = 1'b1; d_sat = 1'b0; d_load = 1'b0; d_load_val = '0;

`ifndef COUNTER_PRESCALE_EN
    //   rst en up sat ld lv  count wrap at_limit
    // Reset dominates load/en, then three up steps.
    add(0, 1, 1, 0, 1,  5,  0, 0, 0);
    add(0, 1, 1, 0, 1,  5,  0, 0, 0);
    add(1, 1, 1, 0, 0,  0,  1, 0, 0);
    add(1, 1, 1, 0, 0,  0,  2, 0, 0);
    add(1, 1, 1, 0, 0,  0,  3, 0, 0);
    // Up wrap from 8.
    add(1, 0, 1, 0, 1,  8,  8, 0, 0);
    add(1, 1, 1, 0, 0,  0,  9, 0, 1);
    add(1, 1, 1, 0, 0,  0,  0, 1, 0);
    add(1, 1, 1, 0, 0,  0,  1, 0, 0);
    // Down saturate from 1, then switch to wrap.
    add(1, 0, 0, 1, 1,  1,  1, 0, 0);
    add(1, 1, 0, 1, 0,  0,  0, 0, 1);
    add(1, 1, 0, 1, 0,  0,  0, 0, 1);
    add(1, 1, 0, 1, 0,  0,  0, 0, 1);
    add(1, 1, 0, 1, 0,  0,  0, 0, 1);
    add(1, 1, 0, 0, 0,  0,  9, 1, 0);
    add(1, 1, 0, 0, 0,  0,  8, 0, 0);
    // Load clamp beats en; reset beats load.
    add(1, 1, 1, 0, 1, 15,  9, 0, 1);
    add(0, 1, 1, 0, 1, 15,  0, 0, 0);
    // Enable gating from 2.
    add(1, 0, 1, 0, 1,  2,  2, 0, 0);
    add(1, 1, 1, 0, 0,  0,  3, 0, 0);
    add(1, 0, 1, 0, 0,  0,  3, 0, 0);
    add(1, 1, 1, 0, 0,  0,  4, 0, 0);
    add(1, 0, 1, 0, 0,  0,  4, 0, 0);
    // Saturate at top: held, no pulse, at_limit flips with direction.
    add(1, 0, 1, 1, 1,  9,  9, 0, 1);
    add(1, 1, 1, 1, 0,  0,  9, 0, 1);
    add(1, 0, 0, 1, 0,  0,  9, 0, 0);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].ld, vecs[i].lv);
      check($sformatf("vec%0d.count", i), int'(count), vecs[i].c);
      check($sformatf("vec%0d.wrap", i), int'(wrap), int'(vecs[i].w));
      check($sformatf("vec%0d.at_limit", i), int'(at_limit), int'(vecs[i].al));
    end

    // Default-parameter instance: MAX_VAL=15, wrap from the top.
    dcyc(0, 0, 0, 4'd0);
    check("def.reset", int'(d_count), 0);
    dcyc(1, 0, 1, 4'd14);
    check("def.load14", int'(d_count), 14);
    dcyc(1, 1, 0, 4'd0);
    check("def.up15", int'(d_count), 15);
    check("def.at_limit15", int'(d_at_limit), 1);
    dcyc(1, 1, 0, 4'd0);
    check("def.wrap_count", int'(d_count), 0);
    check("def.wrap_pulse", int'(d_wrap), 1);
    dcyc(1, 1, 0, 4'd0);
    check("def.after_wrap", int'(d_count), 1);
    check("def.pulse_end", int'(d_wrap), 0);
`else
    // Prescaled stepping: four enabled edges per step, load restarts it.
    cyc(0, 1, 1, 0, 0, '0);
    check("pre.reset", int'(count), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 1, 1, 0, 0, '0);
      check($sformatf("pre.hold%0d", k), int'(count), 0);
    end
    cyc(1, 1, 1, 0, 0, '0);
    check("pre.step1", int'(count), 1);
    cyc(1, 0, 1, 0, 0, '0);
    check("pre.idle_hold", int'(count), 1);
    cyc(1, 1, 1, 0, 0, '0);
    cyc(1, 1, 1, 0, 0, '0);
    check("pre.mid", int'(count), 1);
    cyc(1, 1, 1, 0, 1, 4'd5);
    check("pre.load", int'(count), 5);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 1, 1, 0, 0, '0);
      check($sformatf("pre.reload_hold%0d", k), int'(count), 5);
    end
    cyc(1, 1, 1, 0, 0, '0);
    check("pre.reload_step", int'(count), 6);
`endif

    // Randomized phase against the behavioural model.
    m_count = 0; m_pre = 0; m_wrap = 0;
    for (int n = 0; n < 600; n++) begin
      logic r, e, u, s, l;
      logic [W-1:0] v;
      r = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      e = ($urandom_range(0, 9) < 7);
      u = (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 1);
      l = ($urandom_range(0, 19) == 0);
      v = W'($urandom_range(0, 15));
      cyc(r, e, u, s, l, v);
      model_step(r, e, u, s, l, int'(v));
      check($sformatf("rnd%0d.count", n), int'(count), m_count);
      check($sformatf("rnd%0d.wrap", n), int'(wrap), int'(m_wrap));
      check($sformatf("rnd%0d.at_limit", n), int'(at_limit),
            int'((u && m_count == MAX) || (!u && m_count == 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_updown_mod_counter
